// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, redirect/flush and out-of-range fault handling.
// Optional macro FETCH_ALIGN_CHECK_EN turns a misaligned redirect target into a FAULT with misalign_o set.
module fetch_stage #(
    parameter int                      DATA_WIDTH    = 32,
    parameter int                      ADDRESS_WIDTH = 32,
    parameter int                      MEM_SIZE      = 256,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR    = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
    output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0]    imem_instr_i,
    output logic                     ifid_valid_o,
    output logic [ADDRESS_WIDTH-1:0] ifid_pc_o,
    output logic [ADDRESS_WIDTH-1:0] ifid_pc_plus4_o,
    output logic [DATA_WIDTH-1:0]    ifid_instr_o,
    output logic                     fault_o,
    output logic                     misalign_o
);

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_e;

    localparam logic [ADDRESS_WIDTH-1:0] MEM_BYTES = ADDRESS_WIDTH'(MEM_SIZE * 4);

    state_e                     state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   pc_q, pc_d;
    logic                       valid_q, valid_d;
    logic [ADDRESS_WIDTH-1:0]   ifid_pc_q, ifid_pc_d;
    logic [ADDRESS_WIDTH-1:0]   ifid_pc4_q, ifid_pc4_d;
    logic [DATA_WIDTH-1:0]      instr_q, instr_d;
    logic                       misalign_q, misalign_d;

    logic [ADDRESS_WIDTH-1:0]   target_aligned;
    logic [ADDRESS_WIDTH-1:0]   pc_plus4;
    logic                       target_misaligned;
    logic                       target_in_range;
    logic                       pc_in_range;

    assign target_aligned  = {redirect_target_i[ADDRESS_WIDTH-1:2], 2'b00};
    assign pc_plus4        = pc_q + ADDRESS_WIDTH'(4);
    assign target_in_range = (target_aligned < MEM_BYTES);
    assign pc_in_range     = (pc_q < MEM_BYTES);

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_misaligned = (redirect_target_i[1:0] != 2'b00);
`else
    logic unused_target_low;
    assign unused_target_low = ^redirect_target_i[1:0];
    assign target_misaligned = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        ifid_pc_d  = ifid_pc_q;
        ifid_pc4_d = ifid_pc4_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;

        if (redirect_i) begin
            // Redirect wins in every state; an out-of-range target from FAULT stays faulted.
            pc_d       = target_aligned;
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            misalign_d = target_misaligned;
            if (target_misaligned || (state_q == FAULT && !target_in_range)) begin
                state_d = FAULT;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (!pc_in_range) begin
                        state_d = FAULT;
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end else if (!stall_i) begin
                        valid_d    = 1'b1;
                        ifid_pc_d  = pc_q;
                        ifid_pc4_d = pc_plus4;
                        instr_d    = imem_instr_i;
                        pc_d       = pc_plus4;
                    end
                end
                FAULT: valid_d = 1'b0;
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            ifid_pc_q  <= '0;
            ifid_pc4_q <= '0;
            instr_q    <= NOP_INSTR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            ifid_pc_q  <= ifid_pc_d;
            ifid_pc4_q <= ifid_pc4_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr_o     = pc_q;
    assign ifid_valid_o    = valid_q;
    assign ifid_pc_o       = ifid_pc_q;
    assign ifid_pc_plus4_o = ifid_pc4_q;
    assign ifid_instr_o    = instr_q;
    assign fault_o         = (state_q == FAULT);
    assign misalign_o      = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, redirect, out-of-range fault, misaligned redirect, async reset.
// Memory model returns 32'h1000_0000 + word index for every address.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc_plus4_o;
    logic [31:0] ifid_instr_o;
    logic        fault_o;
    logic        misalign_o;

    int testCount = 0;
    int failCount = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    assign imem_instr_i = 32'h1000_0000 + {2'b00, imem_addr_o[31:2]};

    fetch_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .imem_addr_o       (imem_addr_o),
        .imem_instr_i      (imem_instr_i),
        .ifid_valid_o      (ifid_valid_o),
        .ifid_pc_o         (ifid_pc_o),
        .ifid_pc_plus4_o   (ifid_pc_plus4_o),
        .ifid_instr_o      (ifid_instr_o),
        .fault_o           (fault_o),
        .misalign_o        (misalign_o)
    );

    task automatic applyStimulus(input logic stall, input logic redirect, input logic [31:0] target);
        stall_i           = stall;
        redirect_i        = redirect;
        redirect_target_i = target;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_addr"},  imem_addr_o, 32'h0);
        checkOutput({tag, "_valid"}, {31'b0, ifid_valid_o}, 32'h0);
        checkOutput({tag, "_pc"},    ifid_pc_o, 32'h0);
        checkOutput({tag, "_pc4"},   ifid_pc_plus4_o, 32'h0);
        checkOutput({tag, "_instr"}, ifid_instr_o, NOP);
        checkOutput({tag, "_fault"}, {31'b0, fault_o}, 32'h0);
        checkOutput({tag, "_mis"},   {31'b0, misalign_o}, 32'h0);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #12;
        checkReset("reset");

        // Boot and first three fetches
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("boot_valid", {31'b0, ifid_valid_o}, 32'h0);
        checkOutput("boot_addr", imem_addr_o, 32'h0);
        tick();
        checkOutput("f0_pc", ifid_pc_o, 32'h0);
        checkOutput("f0_pc4", ifid_pc_plus4_o, 32'h4);
        checkOutput("f0_instr", ifid_instr_o, 32'h1000_0000);
        checkOutput("f0_valid", {31'b0, ifid_valid_o}, 32'h1);
        tick();
        checkOutput("f1_pc", ifid_pc_o, 32'h4);
        checkOutput("f1_instr", ifid_instr_o, 32'h1000_0001);
        checkOutput("f1_addr", imem_addr_o, 32'h8);

        // Three-cycle stall at pc=8
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_pc", ifid_pc_o, 32'h4);
            checkOutput("stall_addr", imem_addr_o, 32'h8);
            checkOutput("stall_valid", {31'b0, ifid_valid_o}, 32'h1);
        end
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("resume_pc", ifid_pc_o, 32'h8);
        checkOutput("resume_instr", ifid_instr_o, 32'h1000_0002);

        // Redirect to 0x40 while stalled
        applyStimulus(1'b1, 1'b1, 32'h40);
        tick();
        checkOutput("redir_valid", {31'b0, ifid_valid_o}, 32'h0);
        checkOutput("redir_instr", ifid_instr_o, NOP);
        checkOutput("redir_addr", imem_addr_o, 32'h40);
        checkOutput("redir_pc_hold", ifid_pc_o, 32'h8);
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("redir_fetch_pc", ifid_pc_o, 32'h40);
        checkOutput("redir_fetch_valid", {31'b0, ifid_valid_o}, 32'h1);
        checkOutput("redir_fetch_instr", ifid_instr_o, 32'h1000_0010);

        // Run to the end of memory
        guard = 0;
        while (imem_addr_o != 32'h400 && guard < 400) begin
            tick();
            guard++;
        end
        checkOutput("reach_0x400", imem_addr_o, 32'h400);
        checkOutput("last_pc", ifid_pc_o, 32'h3FC);
        checkOutput("last_pc4", ifid_pc_plus4_o, 32'h400);
        checkOutput("last_instr", ifid_instr_o, 32'h1000_00FF);
        checkOutput("last_valid", {31'b0, ifid_valid_o}, 32'h1);
        tick();
        checkOutput("fault_set", {31'b0, fault_o}, 32'h1);
        checkOutput("fault_valid", {31'b0, ifid_valid_o}, 32'h0);
        checkOutput("fault_addr", imem_addr_o, 32'h400);
        checkOutput("fault_instr", ifid_instr_o, NOP);
        checkOutput("fault_mis", {31'b0, misalign_o}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("fault_hold", {31'b0, fault_o}, 32'h1);
        checkOutput("fault_hold_addr", imem_addr_o, 32'h400);
        applyStimulus(1'b0, 1'b1, 32'h0);
        tick();
        checkOutput("recover_fault", {31'b0, fault_o}, 32'h0);
        checkOutput("recover_addr", imem_addr_o, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("recover_pc", ifid_pc_o, 32'h0);
        checkOutput("recover_valid", {31'b0, ifid_valid_o}, 32'h1);
        checkOutput("recover_instr", ifid_instr_o, 32'h1000_0000);

        // Misaligned redirect
        applyStimulus(1'b0, 1'b1, 32'h42);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("mis_fault", {31'b0, fault_o}, 32'h1);
        checkOutput("mis_flag", {31'b0, misalign_o}, 32'h1);
        checkOutput("mis_addr", imem_addr_o, 32'h40);
        checkOutput("mis_valid", {31'b0, ifid_valid_o}, 32'h0);
        tick();
        checkOutput("mis_sticky", {31'b0, misalign_o}, 32'h1);
        checkOutput("mis_hold_addr", imem_addr_o, 32'h40);
`else
        checkOutput("mis_fault", {31'b0, fault_o}, 32'h0);
        checkOutput("mis_flag", {31'b0, misalign_o}, 32'h0);
        checkOutput("mis_addr", imem_addr_o, 32'h40);
        tick();
        checkOutput("mis_fetch_pc", ifid_pc_o, 32'h40);
        checkOutput("mis_fetch_instr", ifid_instr_o, 32'h1000_0010);
        checkOutput("mis_fetch_valid", {31'b0, ifid_valid_o}, 32'h1);
`endif

        // Mid-stream asynchronous reset near pc=0x20
        applyStimulus(1'b0, 1'b1, 32'h1C);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("pre_rst_fault", {31'b0, fault_o}, 32'h0);
        checkOutput("pre_rst_mis", {31'b0, misalign_o}, 32'h0);
        tick();
        checkOutput("pre_rst_pc", ifid_pc_o, 32'h1C);
        checkOutput("pre_rst_addr", imem_addr_o, 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("reboot_valid", {31'b0, ifid_valid_o}, 32'h0);
        checkOutput("reboot_addr", imem_addr_o, 32'h0);
        tick();
        checkOutput("reboot_pc", ifid_pc_o, 32'h0);
        checkOutput("reboot_instr", ifid_instr_o, 32'h1000_0000);
        checkOutput("reboot_valid2", {31'b0, ifid_valid_o}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
